// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled mm:ss up/down counter with run/pause/done control.
// Accepts a saturating preset load and simultaneous pulses with clear > load > start_stop priority.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       dir,
   input  logic       load,
   input  logic [6:0] ld_min,
   input  logic [3:0] ld_sec_t,
   input  logic [3:0] ld_sec_u,
   output logic [6:0] min,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       running,
   output logic       done,
   output logic       tick
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;

   logic [6:0] nxt_min;
   logic [3:0] nxt_sec_t;
   logic [3:0] nxt_sec_u;
   logic       nxt_zero;
   logic       cur_zero;
   logic       wrap;
   logic [6:0] sat_min;
   logic [3:0] sat_sec_t;
   logic [3:0] sat_sec_u;

   // Time value one tick ahead in the currently selected direction
   always_comb begin
      nxt_min   = min;
      nxt_sec_t = sec_t;
      nxt_sec_u = sec_u;
      if (!dir) begin
         if (sec_u == 4'd9) begin
            nxt_sec_u = 4'd0;
            if (sec_t == 4'd5) begin
               nxt_sec_t = 4'd0;
               nxt_min   = (min == 7'd59) ? 7'd0 : min + 7'd1;
            end else begin
               nxt_sec_t = sec_t + 4'd1;
            end
         end else begin
            nxt_sec_u = sec_u + 4'd1;
         end
      end else begin
         if (sec_u == 4'd0) begin
            nxt_sec_u = 4'd9;
            if (sec_t == 4'd0) begin
               nxt_sec_t = 4'd5;
               nxt_min   = (min == 7'd0) ? 7'd59 : min - 7'd1;
            end else begin
               nxt_sec_t = sec_t - 4'd1;
            end
         end else begin
            nxt_sec_u = sec_u - 4'd1;
         end
      end
   end

   assign nxt_zero  = (nxt_min == 7'd0) && (nxt_sec_t == 4'd0) && (nxt_sec_u == 4'd0);
   assign cur_zero  = (min == 7'd0) && (sec_t == 4'd0) && (sec_u == 4'd0);
   assign wrap      = (presc == P_LAST);
   assign sat_min   = (ld_min   > 7'd59) ? 7'd59 : ld_min;
   assign sat_sec_t = (ld_sec_t > 4'd5)  ? 4'd5  : ld_sec_t;
   assign sat_sec_u = (ld_sec_u > 4'd9)  ? 4'd9  : ld_sec_u;

   // State, prescaler, time and flags; running/done are written on every state change
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         presc   <= '0;
         min     <= 7'd0;
         sec_t   <= 4'd0;
         sec_u   <= 4'd0;
         running <= 1'b0;
         done    <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clear) begin
            state   <= S_IDLE;
            presc   <= '0;
            min     <= 7'd0;
            sec_t   <= 4'd0;
            sec_u   <= 4'd0;
            running <= 1'b0;
            done    <= 1'b0;
         end else if (load && state != S_RUN) begin
            presc <= '0;
            min   <= sat_min;
            sec_t <= sat_sec_t;
            sec_u <= sat_sec_u;
            if (state == S_DONE) begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_stop) begin
                     presc <= '0;
                     if (dir && cur_zero) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state   <= S_RUN;
                        running <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (wrap) begin
                     presc <= '0;
                     tick  <= 1'b1;
                     min   <= nxt_min;
                     sec_t <= nxt_sec_t;
                     sec_u <= nxt_sec_u;
                  end else begin
                     presc <= presc + PW'(1);
                  end
                  if (wrap && dir && nxt_zero) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end else if (start_stop) begin
                     state   <= S_PAUSE;
                     running <= 1'b0;
                  end
               end
               S_PAUSE: begin
                  if (start_stop) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end
               end
               default: begin
                  if (start_stop) begin
                     state <= S_IDLE;
                     done  <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random pulses, checked every cycle
// against a model that keeps time as a plain count of seconds.
module tb_stopwatch_ctrl;

   localparam int unsigned TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [6:0] ld_min = 7'd0;
   logic [3:0] ld_sec_t = 4'd0;
   logic [3:0] ld_sec_u = 4'd0;
   logic [6:0] min;
   logic [3:0] sec_t;
   logic [3:0] sec_u;
   logic       running;
   logic       done;
   logic       tick;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .dir        (dir),
      .load       (load),
      .ld_min     (ld_min),
      .ld_sec_t   (ld_sec_t),
      .ld_sec_u   (ld_sec_u),
      .min        (min),
      .sec_t      (sec_t),
      .sec_u      (sec_u),
      .running    (running),
      .done       (done),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; time in seconds 0..3599
   int m_mode = 0;
   int m_secs = 0;
   int m_presc = 0;
   int m_tick = 0;

   function automatic int clip(input int v, input int hi);
      return (v > hi) ? hi : v;
   endfunction

   function automatic void model_step();
      m_tick = 0;
      if (rst) begin
         m_mode = 0; m_secs = 0; m_presc = 0;
      end else if (clear) begin
         m_mode = 0; m_secs = 0; m_presc = 0;
      end else if (load && m_mode != 1) begin
         m_secs  = clip(int'(ld_min), 59) * 60 + clip(int'(ld_sec_t), 5) * 10 + clip(int'(ld_sec_u), 9);
         m_presc = 0;
         if (m_mode == 3) m_mode = 0;
      end else if (m_mode == 0) begin
         if (start_stop) begin
            m_presc = 0;
            m_mode  = (dir && m_secs == 0) ? 3 : 1;
         end
      end else if (m_mode == 1) begin
         if (m_presc == TD - 1) begin
            m_presc = 0;
            m_tick  = 1;
            m_secs  = dir ? (m_secs + 3599) % 3600 : (m_secs + 1) % 3600;
            if (dir && m_secs == 0) m_mode = 3;
            else if (start_stop) m_mode = 2;
         end else begin
            m_presc = m_presc + 1;
            if (start_stop) m_mode = 2;
         end
      end else if (m_mode == 2) begin
         if (start_stop) m_mode = 1;
      end else begin
         if (start_stop) m_mode = 0;
      end
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge: advance model, then compare all outputs away from the edge
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("min",     int'(min),     m_secs / 60);
      check("sec_t",   int'(sec_t),   (m_secs % 60) / 10);
      check("sec_u",   int'(sec_u),   m_secs % 10);
      check("running", int'(running), (m_mode == 1) ? 1 : 0);
      check("done",    int'(done),    (m_mode == 3) ? 1 : 0);
      check("tick",    int'(tick),    m_tick);
   endtask

   task automatic cyc(input logic ss, input logic cl, input logic ld);
      start_stop = ss; clear = cl; load = ld;
      step();
      start_stop = 1'b0; clear = 1'b0; load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input int m, input int t, input int u);
      ld_min = 7'(m); ld_sec_t = 4'(t); ld_sec_u = 4'(u);
      cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_time(input string tag, input int m, input int t, input int u);
      check({tag, "_min"}, int'(min), m);
      check({tag, "_st"},  int'(sec_t), t);
      check({tag, "_su"},  int'(sec_u), u);
   endtask

   initial begin
      // Reset
      idle(2);
      rst = 1'b0;
      check_time("reset", 0, 0, 0);
      check("reset_flags", int'({running, done, tick}), 0);

      // Up rollover 00:59 -> 01:00, then 59:59 -> 00:00 without done
      dir = 1'b0;
      do_load(0, 5, 9);
      cyc(1'b1, 1'b0, 1'b0);
      idle(3);
      check("up_pre_tick", int'(tick), 0);
      step();
      check("up_tick", int'(tick), 1);
      check_time("up_0100", 1, 0, 0);
      cyc(1'b0, 1'b1, 1'b0);
      do_load(59, 5, 9);
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      check_time("up_wrap", 0, 0, 0);
      check("up_wrap_run", int'(running), 1);
      check("up_wrap_done", int'(done), 0);
      cyc(1'b0, 1'b1, 1'b0);

      // Countdown 01:00 -> 00:59, then 00:01 -> 00:00 into DONE
      dir = 1'b1;
      do_load(1, 0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      check_time("dn_0059", 0, 5, 9);
      cyc(1'b0, 1'b1, 1'b0);
      do_load(0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      check_time("dn_end", 0, 0, 0);
      check("dn_done", int'(done), 1);
      check("dn_running", int'(running), 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("dn_no_tick", int'(tick), 0);
      end
      cyc(1'b0, 1'b1, 1'b0);

      // Pause after 2 RUN cycles, resume, tick after exactly 2 more
      dir = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      step();
      cyc(1'b1, 1'b0, 1'b0);
      check("pause_state", int'(running), 0);
      idle(10);
      check_time("pause_hold", 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      check("resume_t0", int'(tick), 0);
      step();
      check("resume_t1", int'(tick), 0);
      step();
      check("resume_tick", int'(tick), 1);
      check_time("resume_time", 0, 0, 1);
      cyc(1'b0, 1'b1, 1'b0);

      // Saturating load, then a load in RUN is ignored
      do_load(75, 7, 12);
      check_time("sat", 59, 5, 9);
      cyc(1'b1, 1'b0, 1'b0);
      step();
      do_load(3, 3, 3);
      check_time("run_load", 59, 5, 9);
      check("run_load_state", int'(running), 1);
      cyc(1'b0, 1'b1, 1'b0);

      // Priority clear > load > start_stop from PAUSE; zero countdown start
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      ld_min = 7'd5; ld_sec_t = 4'd1; ld_sec_u = 4'd1;
      cyc(1'b1, 1'b1, 1'b1);
      check_time("prio", 0, 0, 0);
      check("prio_flags", int'({running, done}), 0);
      dir = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      check("zero_start_done", int'(done), 1);
      check("zero_start_tick", int'(tick), 0);
      cyc(1'b0, 1'b1, 1'b0);

      // Reset mid-RUN at prescaler 3
      dir = 1'b0;
      do_load(0, 0, 7);
      cyc(1'b1, 1'b0, 1'b0);
      idle(3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_time("rst_run", 0, 0, 0);
      check("rst_run_flags", int'({running, done, tick}), 0);

      // Random pulses with the model checking every cycle
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         clear      = ($urandom_range(0, 99) == 0);
         load       = ($urandom_range(0, 29) == 0);
         start_stop = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 49) == 0) dir = ~dir;
         ld_min   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
         ld_sec_t = 4'($urandom_range(0, 7));
         ld_sec_u = 4'($urandom_range(0, 15));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100, clk cycles per count tick; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-005 clear  input  1  single-cycle pulse; zeroes time and returns to IDLE.
REQ-006 dir  input  1  0 = count up, 1 = count down.
REQ-007 load  input  1  single-cycle pulse; loads preset time.
REQ-008 ld_min  input  7  preset minutes.
REQ-009 ld_sec_t  input  4  preset seconds-tens digit.
REQ-010 ld_sec_u  input  4  preset seconds-units digit.
REQ-011 min  output  7  minutes, 0..59.
REQ-012 sec_t  output  4  seconds tens, 0..5.
REQ-013 sec_u  output  4  seconds units, 0..9.
REQ-014 running  output  1  high while the FSM is in RUN.
REQ-015 done  output  1  high while the FSM is in DONE.
REQ-016 tick  output  1  one-cycle pulse on each count update.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-018 Transitions SHALL be:
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - RUN --countdown reaches 00:00--> DONE
  - DONE --start_stop--> IDLE
  - any state --clear--> IDLE
REQ-019 Prescaler: in RUN, count 0..TICK_DIV-1; on the wrap cycle, tick=1 and the time SHALL update on that same clock edge.
REQ-020 Prescaler SHALL hold in PAUSE and SHALL reset to 0 on entry to RUN from IDLE, on clear, and on load.
REQ-021 Count up:
  - sec_u 9->0 with carry, otherwise +1
  - sec_t 5->0 with carry on carry-in
  - min 59->0 on carry-in
  - 59:59 SHALL wrap to 00:00, stay in RUN, and SHALL NOT assert done.
REQ-022 Count down:
  - sec_u 0->9 with borrow, otherwise -1
  - sec_t 0->5 with borrow on borrow-in
  - min -1 on borrow-in
  - the tick that produces 00:00 SHALL move the FSM to DONE on the same edge.
REQ-023 In DONE, time SHALL hold, tick SHALL stay 0, and done SHALL stay 1.
REQ-024 start_stop in IDLE with dir=1 and time 00:00 SHALL go to DONE on the next edge, with no tick.
REQ-025 dir is sampled at each tick; a change mid-RUN SHALL take effect at the next tick with no glitch in the digits.
REQ-026 load SHALL be accepted only in IDLE, PAUSE and DONE; in RUN it SHALL be ignored.
REQ-027 An accepted load from DONE SHALL move the FSM to IDLE.
REQ-028 Loaded fields SHALL saturate: ld_sec_u>9 -> 9, ld_sec_t>5 -> 5, ld_min>59 -> 59.
REQ-029 Priority on a simultaneous pulse SHALL be clear > load > start_stop.
REQ-030 A start_stop pulse in the same cycle as a prescaler wrap in RUN SHALL apply the tick, then enter PAUSE.
REQ-031 Outputs SHALL be registered; running and done SHALL follow the state with 0 cycles of extra latency.

Reset
REQ-032 rst SHALL override all inputs.
REQ-033 On rst, the block SHALL enter state IDLE with:
  - min=0, sec_t=0, sec_u=0
  - prescaler=0
  - running=0, done=0, tick=0
REQ-034 rst asserted mid-RUN SHALL abandon the current count; no tick SHALL be issued in the reset cycle.

Verification (TICK_DIV=4)
REQ-035 The bench SHALL cover the following directed scenarios:
  - Up rollover: load 00:59, dir=0, start -> after 4 cycles tick=1 and time 01:00; load 59:59, run one tick -> 00:00, done=0.
  - Countdown end: load 01:00, dir=1, start -> after 1 tick 00:59; load 00:01, run one tick -> 00:00, done=1, running=0, no further ticks.
  - Pause/resume: start, pause after 2 cycles, wait 10 cycles, resume -> next tick after exactly 2 more RUN cycles; time unchanged during PAUSE.
  - Saturating load: load ld_min=75, ld_sec_t=7, ld_sec_u=12 in IDLE -> 59:59; load pulse in RUN -> time and state unchanged.
  - Priority: clear+load+start_stop in one cycle from PAUSE -> IDLE, 00:00; start_stop in IDLE with dir=1 at 00:00 -> DONE next cycle, tick=0.
  - Reset mid-RUN: rst at prescaler=3 -> next cycle IDLE, 00:00, all flags 0, tick=0.
